// File: rtl/adder_pkg.sv
// adder_pkg: shared state encoding and default width for the bit-serial adder.
package adder_pkg;
   localparam int DEF_WIDTH = 8;
   typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;
endpackage

// File: rtl/fa_cell.sv
// fa_cell: combinational 1-bit full adder built from two half adders.
//   a, b : operand bits
//   cin  : carry in
//   sum  : sum bit
//   cout : carry out (OR of both half-adder carries; they are never both set)
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);
   logic s0, c0, c1;
   halfadder h0 (.a(a),  .b(b),   .s(s0),  .c(c0));
   halfadder h1 (.a(s0), .b(cin), .s(sum), .c(c1));
   assign cout = c0 | c1;
endmodule

// File: rtl/halfadder.sv
// halfadder: combinational 1-bit half adder.
//   a, b : addend bits
//   s    : sum bit (a ^ b)
//   c    : carry bit (a & b)
module halfadder (
   input  logic a,
   input  logic b,
   output logic s,
   output logic c
);
   assign s = a ^ b;
   assign c = a & b;
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial WIDTH-bit adder, one full-adder cell reused LSB first.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   start      : request, accepted whenever not busy (IDLE or FIN)
//   a, b       : operands, captured on the accepted start edge
//   busy       : high while bits are being processed
//   done       : one-cycle pulse when sum/carry become valid
//   sum, carry : {carry,sum} = a + b, held until the next result is produced
module serial_adder_ctrl
   import adder_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry
);
   state_t st, nx;
   logic [WIDTH-1:0] a_sr, b_sr, sum_sr;
   logic [CNT_W-1:0] cnt;
   logic cf, cs, cc, last, accept;

   fa_cell u_fa (.a(a_sr[0]), .b(b_sr[0]), .cin(cf), .sum(cs), .cout(cc));

   assign busy   = st == SHIFT;
   assign done   = st == FIN;
   assign last   = cnt == CNT_W'(WIDTH - 1);
   // FIN accepts start too, giving back-to-back adds with no idle gap
   assign accept = start && !busy;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) st <= IDLE;
      else        st <= nx;

   always_comb begin
      nx = st;
      case (st)
         IDLE:    nx = start ? SHIFT : IDLE;
         SHIFT:   nx = last ? FIN : SHIFT;
         FIN:     nx = start ? SHIFT : IDLE;
         default: nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         a_sr   <= '0;
         b_sr   <= '0;
         sum_sr <= '0;
         cf     <= 1'b0;
         cnt    <= '0;
         sum    <= '0;
         carry  <= 1'b0;
      end else if (accept) begin
         a_sr <= a;
         b_sr <= b;
         cf   <= 1'b0;
         cnt  <= '0;
      end else if (busy) begin
         a_sr   <= a_sr >> 1;
         b_sr   <= b_sr >> 1;
         sum_sr <= {cs, sum_sr[WIDTH-1:1]};
         cf     <= cc;
         cnt    <= cnt + 1'b1;
         // the final bit goes straight into the result so it is valid in FIN
         if (last) begin
            sum   <= {cs, sum_sr[WIDTH-1:1]};
            carry <= cc;
         end
      end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: scoreboard bench for serial_adder_ctrl at WIDTH=8 and WIDTH=32.
module tb_serial_adder_ctrl;
   logic clk = 1'b0;
   logic rst_n;
   logic start8, start32;
   logic [7:0] a8, b8, s8;
   logic [31:0] a32, b32, s32;
   logic busy8, done8, c8, busy32, done32, c32;
   logic prev_done8 = 1'b0, prev_done32 = 1'b0;
   logic [8:0] q8[$];
   logic [32:0] q32[$];
   logic [8:0] e8;
   logic [32:0] e32;
   int errs = 0, checks = 0, ndone8 = 0, ndone32 = 0;

   serial_adder_ctrl #(.WIDTH(8)) u8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .sum(s8), .carry(c8)
   );
   serial_adder_ctrl #(.WIDTH(32)) u32 (
      .clk(clk), .rst_n(rst_n), .start(start32), .a(a32), .b(b32),
      .busy(busy32), .done(done32), .sum(s32), .carry(c32)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         checks++;
         if (done8 && busy8) begin errs++; $display("FAIL overlap8 done=%b busy=%b required not both", done8, busy8); end
         checks++;
         if (done8 && prev_done8) begin errs++; $display("FAIL width8 done high 2 cycles, required 1"); end
         checks++;
         if (done32 && busy32) begin errs++; $display("FAIL overlap32 done=%b busy=%b required not both", done32, busy32); end
         checks++;
         if (done32 && prev_done32) begin errs++; $display("FAIL width32 done high 2 cycles, required 1"); end
         if (done8) begin
            ndone8++;
            checks++;
            if (q8.size() == 0) begin
               errs++; $display("FAIL unexpected_done8 sum=%h carry=%b", s8, c8);
            end else begin
               e8 = q8.pop_front();
               if ({c8, s8} !== e8) begin errs++; $display("FAIL result8 got %h required %h", {c8, s8}, e8); end
            end
         end
         if (done32) begin
            ndone32++;
            checks++;
            if (q32.size() == 0) begin
               errs++; $display("FAIL unexpected_done32 sum=%h carry=%b", s32, c32);
            end else begin
               e32 = q32.pop_front();
               if ({c32, s32} !== e32) begin errs++; $display("FAIL result32 got %h required %h", {c32, s32}, e32); end
            end
         end
      end
      prev_done8 = done8;
      prev_done32 = done32;
   end

   task automatic go8(input logic [7:0] x, input logic [7:0] y);
      @(negedge clk);
      start8 = 1'b1; a8 = x; b8 = y;
      q8.push_back({1'b0, x} + {1'b0, y});
      @(negedge clk);
      start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
   endtask

   task automatic wait8(input string name);
      int n = 0;
      while (q8.size() != 0 && n < 100) begin @(negedge clk); n++; end
      checks++;
      if (q8.size() != 0) begin errs++; $display("FAIL %s timeout pending=%0d required 0", name, q8.size()); q8.delete(); end
   endtask

   task automatic test_reset;
      int nb = 0;
      rst_n = 1'b0; start8 = 1'b0; start32 = 1'b0;
      a8 = '0; b8 = '0; a32 = '0; b32 = '0;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy8, done8, c8, s8} !== 11'd0) begin errs++; $display("FAIL reset8 got %b required 0", {busy8, done8, c8, s8}); end
      checks++;
      if ({busy32, done32, c32, s32} !== 35'd0) begin errs++; $display("FAIL reset32 got %h required 0", {busy32, done32, c32, s32}); end
      rst_n = 1'b1;
      @(negedge clk);
      go8(8'h00, 8'h00);
      while (busy8 && nb < 50) begin nb++; @(negedge clk); end
      checks++;
      if (nb != 8) begin errs++; $display("FAIL busy_len got %0d required 8", nb); end
      checks++;
      if (done8 !== 1'b1) begin errs++; $display("FAIL latency done=%b required 1 after busy", done8); end
      wait8("zero_add");
   endtask

   task automatic test_basic;
      go8(8'h5A, 8'h3C); wait8("add_5a_3c");
      go8(8'hFF, 8'h01); wait8("add_ff_01");
      go8(8'hFF, 8'hFF); wait8("add_ff_ff");
   endtask

   task automatic test_ignore_busy;
      int nd;
      nd = ndone8;
      go8(8'h12, 8'h34);
      @(negedge clk);
      start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
      @(negedge clk);
      start8 = 1'b0;
      wait8("ignore_busy");
      repeat (12) @(negedge clk);
      checks++;
      if (ndone8 - nd != 1) begin errs++; $display("FAIL single_done got %0d pulses required 1", ndone8 - nd); end
   endtask

   task automatic test_back_to_back;
      int n = 0;
      @(negedge clk);
      start8 = 1'b1; a8 = 8'h80; b8 = 8'h80;
      q8.push_back(9'h100);
      @(negedge clk);
      start8 = 1'b0;
      while (!done8 && n < 50) begin n++; @(negedge clk); end
      checks++;
      if (done8 !== 1'b1) begin errs++; $display("FAIL b2b_first done=%b required 1", done8); end
      start8 = 1'b1; a8 = 8'h01; b8 = 8'h02;
      q8.push_back(9'h003);
      @(negedge clk);
      start8 = 1'b0;
      checks++;
      if (busy8 !== 1'b1) begin errs++; $display("FAIL b2b_accept busy=%b required 1", busy8); end
      wait8("back_to_back");
   endtask

   task automatic test_async_reset;
      int nd;
      go8(8'hAA, 8'h55);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({busy8, done8, c8, s8} !== 11'd0) begin errs++; $display("FAIL async_reset got %b required 0", {busy8, done8, c8, s8}); end
      q8.delete();
      @(negedge clk);
      rst_n = 1'b1;
      nd = ndone8;
      repeat (15) @(negedge clk);
      checks++;
      if (ndone8 != nd) begin errs++; $display("FAIL aborted_done got %0d pulses required 0", ndone8 - nd); end
      go8(8'h0F, 8'hF1); wait8("after_reset");
   endtask

   task automatic test_random;
      logic [31:0] x, y;
      int n;
      for (int i = 0; i < 1000; i++) begin go8(8'($urandom), 8'($urandom)); wait8("rand8"); end
      for (int i = 0; i < 1000; i++) begin
         x = $urandom; y = $urandom;
         @(negedge clk);
         start32 = 1'b1; a32 = x; b32 = y;
         q32.push_back({1'b0, x} + {1'b0, y});
         @(negedge clk);
         start32 = 1'b0; a32 = $urandom; b32 = $urandom;
         n = 0;
         while (q32.size() != 0 && n < 100) begin @(negedge clk); n++; end
         checks++;
         if (q32.size() != 0) begin errs++; $display("FAIL rand32 timeout pending=%0d required 0", q32.size()); q32.delete(); end
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_ignore_busy;
      test_back_to_back;
      test_async_reset;
      test_random;
      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
